// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine that owns HI/LO.
// One shift-add (multiply) or restoring-subtract (divide) step per clock,
// 32 steps per operation.
// Optional MTHI/MTLO write port: define MD_HILO_WRITE_EN.
//
// state | meaning
// IDLE  | waiting for start; HI/LO hold; optional write port is live
// RUN   | one multiply/divide step per edge, count 0..31
// DONE  | one-cycle done pulse; HI/LO hold the result
module mult_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  MD_Control,
   input  logic [31:0] InA,
   input  logic [31:0] InB,
`ifdef MD_HILO_WRITE_EN
   input  logic        hilo_we,
   input  logic        hilo_sel,
   input  logic [31:0] hilo_wdata,
`endif
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q;
   logic        is_div_q;
   logic        neg_res_q;   // product / quotient must be negated
   logic        neg_rem_q;   // remainder must be negated (dividend was negative)
   logic [31:0] opnd_q;      // multiplicand or divisor magnitude
   logic [63:0] acc_q;       // {partial product | remainder, multiplier | dividend->quotient}
   logic [31:0] hi_q, lo_q;
   logic        dbz_q;

   logic        accept, div_zero, signed_op;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift, div_diff;
   logic        div_ge;
   logic        unused_div_msb;
   logic [63:0] step;
   logic [63:0] mul_res;
   logic [31:0] quo_res, rem_res;
   logic [31:0] res_hi, res_lo;

   assign signed_op = MD_Control[0];
   assign a_mag     = (signed_op && InA[31]) ? (32'd0 - InA) : InA;
   assign b_mag     = (signed_op && InB[31]) ? (32'd0 - InB) : InB;
   assign accept    = (state_q == S_IDLE) && start;
   assign div_zero  = MD_Control[1] && (InB == 32'd0);

   // One engine step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      mul_sum        = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      div_shift      = {acc_q[63:32], acc_q[31]};
      div_diff       = div_shift - {1'b0, opnd_q};
      div_ge         = (div_shift >= {1'b0, opnd_q});
      unused_div_msb = div_diff[32];
      if (is_div_q)
         step = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
      else
         step = {mul_sum, acc_q[31:1]};
   end

   // Sign fix-up of the final step before it is written to HI/LO.
   always_comb begin
      mul_res = neg_res_q ? (64'd0 - step) : step;
      quo_res = neg_res_q ? (32'd0 - step[31:0]) : step[31:0];
      rem_res = neg_rem_q ? (32'd0 - step[63:32]) : step[63:32];
      res_hi  = is_div_q ? rem_res : mul_res[63:32];
      res_lo  = is_div_q ? quo_res : mul_res[31:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a divide by zero skips RUN entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = div_zero ? S_DONE : S_RUN;
         S_RUN:   if (count_q == 5'd31) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs; busy also covers the accepting cycle so the pipeline stalls at once.
   always_comb begin
      busy = (state_q == S_RUN) || (accept && !div_zero);
      done = (state_q == S_DONE);
   end

   // Operand latch, iteration and HI/LO update.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= 32'd0;
         acc_q     <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         dbz_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
`ifdef MD_HILO_WRITE_EN
               if (hilo_we) begin
                  if (hilo_sel) hi_q <= hilo_wdata;
                  else          lo_q <= hilo_wdata;
               end
`endif
               if (start) begin
                  count_q   <= 5'd0;
                  is_div_q  <= MD_Control[1];
                  neg_res_q <= signed_op && (InA[31] ^ InB[31]);
                  neg_rem_q <= signed_op && InA[31];
                  opnd_q    <= MD_Control[1] ? b_mag : a_mag;
                  acc_q     <= {32'd0, (MD_Control[1] ? a_mag : b_mag)};
                  dbz_q     <= 1'b0;
                  // Divide by zero result overrides any same-cycle register write.
                  if (div_zero) begin
                     hi_q  <= InA;
                     lo_q  <= 32'hFFFF_FFFF;
                     dbz_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               count_q <= count_q + 5'd1;
               acc_q   <= step;
               if (count_q == 5'd31) begin
                  hi_q <= res_hi;
                  lo_q <= res_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_by_zero = dbz_q;
   assign HI          = hi_q;
   assign LO          = lo_q;

endmodule
